calc_host_seq: RTL and testbench



---
 rtl/calc_host_seq.sv | 196 +++++++++++++++++++
 tb/tb_calc_host_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_host_seq.sv
// calc_host_seq: host-side sequencer that drives the calculator device bus.
// Takes one transaction per request beat (command, 0..2 operands, response
// flag). It puts the words on dev_cs/dev_din in back-to-back cycles. It then
// waits for drdy (response expected) or for busy to fall (no response), and
// returns one response beat.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_cmd/op1/op2/nops/rsp      request payload (nops 3 is treated as 2)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             captured result / timeout flag
//   dev_cs, dev_din               device command strobe and data word
//   dev_busy, dev_drdy, dev_dout  device status and result
//   idle                          high while the sequencer is in IDLE
//
// Optional feature: define CALC_HOST_TIMEOUT_EN to bound WAIT/DRAIN to
// TO_CYCLES cycles. A timed-out transaction returns rsp_err=1.
module calc_host_seq #(
  parameter int unsigned DW        = 8,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_cmd,
  input  logic [DW-1:0] req_op1,
  input  logic [DW-1:0] req_op2,
  input  logic [1:0]    req_nops,
  input  logic          req_rsp,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dev_cs,
  output logic [DW-1:0] dev_din,
  input  logic          dev_busy,
  input  logic          dev_drdy,
  input  logic [DW-1:0] dev_dout,
  output logic          idle
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_OP1, S_OP2, S_WAIT, S_DRAIN, S_RSP
  } state_t;

  state_t        state, state_n, post_ops;
  logic [DW-1:0] cmd_q, op1_q, op2_q, cmd_n, op1_n, op2_n;
  logic [1:0]    nops_q, nops_n;
  logic          rspf_q, rspf_n;
  logic          first_q, first_n;   // first DRAIN cycle: busy not yet valid
  logic          rdy_q;              // registered "in IDLE" qualifier for req_ready
  logic [DW-1:0] data_n, din_n;
  logic          err_n;

  // TO_CYCLES must be at least 1; this marker block flags a zero value.
  if (TO_CYCLES == 0) begin : g_to_cycles_zero_unsupported
  end

`ifdef CALC_HOST_TIMEOUT_EN
  localparam int unsigned CW      = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_n;
  logic          to_hit;
  // Count reaches TO_CYCLES at the end of this cycle.
  assign to_hit = (cnt_q == TO_LAST);
`endif

  // Ready is combinational on busy so a busy device blocks acceptance at once.
  assign req_ready = rdy_q && !dev_busy;
  assign post_ops  = rspf_q ? S_WAIT : S_DRAIN;

  // Next-state, payload latching and registered-output next values.
  always_comb begin
    state_n = state;
    cmd_n   = cmd_q;
    op1_n   = op1_q;
    op2_n   = op2_q;
    nops_n  = nops_q;
    rspf_n  = rspf_q;
    data_n  = rsp_data;
    err_n   = rsp_err;
    first_n = 1'b0;
    din_n   = '0;
`ifdef CALC_HOST_TIMEOUT_EN
    cnt_n   = cnt_q;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          cmd_n   = req_cmd;
          op1_n   = req_op1;
          op2_n   = req_op2;
          nops_n  = (req_nops == 2'd3) ? 2'd2 : req_nops;
          rspf_n  = req_rsp;
          state_n = S_CMD;
        end
      end
      S_CMD:   state_n = (nops_q != 2'd0) ? S_OP1 : post_ops;
      S_OP1:   state_n = (nops_q == 2'd2) ? S_OP2 : post_ops;
      S_OP2:   state_n = post_ops;
      S_WAIT: begin
        if (dev_drdy) begin
          data_n  = dev_dout;
          err_n   = 1'b0;
          state_n = S_RSP;
        end
`ifdef CALC_HOST_TIMEOUT_EN
        else if (to_hit) begin
          data_n  = '0;
          err_n   = 1'b1;
          state_n = S_RSP;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
`endif
      end
      S_DRAIN: begin
        if (!first_q && !dev_busy) begin
          data_n  = '0;
          err_n   = 1'b0;
          state_n = S_RSP;
        end
`ifdef CALC_HOST_TIMEOUT_EN
        else if (to_hit) begin
          data_n  = '0;
          err_n   = 1'b1;
          state_n = S_RSP;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
`endif
      end
      S_RSP:   if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Entering WAIT or DRAIN restarts the wait bookkeeping.
    if ((state_n == S_WAIT || state_n == S_DRAIN) && state_n != state) begin
      first_n = 1'b1;
`ifdef CALC_HOST_TIMEOUT_EN
      cnt_n   = '0;
`endif
    end

    case (state_n)
      S_CMD:   din_n = cmd_n;
      S_OP1:   din_n = op1_n;
      S_OP2:   din_n = op2_n;
      default: din_n = '0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      nops_q    <= '0;
      rspf_q    <= 1'b0;
      first_q   <= 1'b0;
      rdy_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      dev_cs    <= 1'b0;
      dev_din   <= '0;
      idle      <= 1'b1;
`ifdef CALC_HOST_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      cmd_q     <= cmd_n;
      op1_q     <= op1_n;
      op2_q     <= op2_n;
      nops_q    <= nops_n;
      rspf_q    <= rspf_n;
      first_q   <= first_n;
      rdy_q     <= (state_n == S_IDLE);
      rsp_valid <= (state_n == S_RSP);
      rsp_data  <= data_n;
      rsp_err   <= err_n;
      dev_cs    <= (state_n == S_CMD);
      dev_din   <= din_n;
      idle      <= (state_n == S_IDLE);
`ifdef CALC_HOST_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_calc_host_seq.sv
// Testbench for calc_host_seq: behavioural device model, transaction-level
// expectation queues and a per-cycle compare process.
module tb_calc_host_seq;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_rsp;
  logic [DW-1:0] req_cmd, req_op1, req_op2;
  logic [1:0]    req_nops;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          dev_cs, dev_busy, dev_drdy, idle;
  logic [DW-1:0] dev_din, dev_dout;

  calc_host_seq #(.DW(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .req_nops(req_nops), .req_rsp(req_rsp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dev_cs(dev_cs), .dev_din(dev_din), .dev_busy(dev_busy), .dev_drdy(dev_drdy),
    .dev_dout(dev_dout), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, cs_cyc = -100, cs_count = 0, acc_cyc = 0, rise_cyc = 0, rsp_done = 0;
  logic [DW-1:0] cs_din, last_data;
  logic          last_err;

  // Device behaviour knobs, fixed for the duration of one transaction.
  bit            cfg_drdy_en = 1'b1, cfg_stray = 1'b0, busy_force = 1'b0;
  int            cfg_drdy_dly = 1, cfg_busy_len = 0, rdy_mode = 1;
  logic [DW-1:0] cfg_dout = '0;

  logic [8:0] bus_q[$];   // {cs, din} per expected bus cycle
  logic [8:0] rsp_q[$];   // {err, data} per expected response
  logic [8:0] w, e;
  logic       in_txn = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_err;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Device model: busy for cfg_busy_len cycles after cs, drdy cfg_drdy_dly cycles after cs.
  initial begin
    dev_busy = 1'b0; dev_drdy = 1'b0; dev_dout = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) cs_cyc = -100;
      if (dev_cs) begin cs_cyc = cyc; cs_count++; cs_din = dev_din; end
      dev_busy = busy_force || (cs_cyc >= 0 && cyc > cs_cyc && cyc <= cs_cyc + cfg_busy_len);
      dev_drdy = (cs_cyc >= 0) && ((cfg_drdy_en && cyc == cs_cyc + cfg_drdy_dly) ||
                                   (cfg_stray && (cyc == cs_cyc + 1 || cyc == cs_cyc + 2)));
      dev_dout = dev_drdy ? cfg_dout : DW'($urandom);
    end
  end

  // Response consumer.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    end
  end

  // Compare process: bus words, idle, ready gating, response hold and value.
  always @(negedge clk) begin
    if (rst) begin
      bus_q.delete(); rsp_q.delete();
      in_txn = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      if (bus_q.size() != 0) begin
        w = bus_q.pop_front();
        chk("bus_cs", 32'(dev_cs), 32'(w[8]));
        chk("bus_din", 32'(dev_din), 32'(w[7:0]));
      end else begin
        chk("bus_cs_quiet", 32'(dev_cs), 32'(0));
        chk("bus_din_quiet", 32'(dev_din), 32'(0));
      end
      chk("idle", 32'(idle), 32'(!in_txn));
      if (dev_busy) chk("ready_vs_busy", 32'(req_ready), 32'(0));
      if (rsp_valid) begin
        chk("ready_in_rsp", 32'(req_ready), 32'(0));
        if (!prev_valid) rise_cyc = cyc;
        else if (!prev_ready) begin
          chk("hold_data", 32'(rsp_data), 32'(prev_data));
          chk("hold_err", 32'(rsp_err), 32'(prev_err));
        end
        if (rsp_ready) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
          else begin
            e = rsp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
            chk("rsp_err", 32'(rsp_err), 32'(e[8]));
          end
          last_data = rsp_data; last_err = rsp_err;
          rsp_done++; in_txn = 1'b0;
        end
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready;
      prev_data = rsp_data; prev_err = rsp_err;
      if (req_valid && req_ready) begin
        bus_q.push_back({1'b1, req_cmd});
        if (req_nops != 2'd0) bus_q.push_back({1'b0, req_op1});
        if (req_nops >= 2'd2) bus_q.push_back({1'b0, req_op2});
`ifdef CALC_HOST_TIMEOUT_EN
        if (req_rsp && !cfg_drdy_en) rsp_q.push_back({1'b1, 8'h00});
        else
`endif
        rsp_q.push_back({1'b0, req_rsp ? cfg_dout : 8'h00});
        in_txn = 1'b1; acc_cyc = cyc;
      end
    end
  end

  task automatic drive_idle_req();
    req_valid = 1'b0;
    req_cmd = DW'($urandom); req_op1 = DW'($urandom); req_op2 = DW'($urandom);
    req_nops = 2'($urandom); req_rsp = 1'($urandom);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] o1, input logic [7:0] o2,
                      input logic [1:0] n, input logic r);
    int k;
    req_cmd = c; req_op1 = o1; req_op2 = o2; req_nops = n; req_rsp = r; req_valid = 1'b1;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (k == 400) chk("accept_wait", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    drive_idle_req();
  endtask

  task automatic wait_done(input int target);
    int k;
    for (k = 0; k < 400; k++) begin
      if (rsp_done >= target) break;
      @(posedge clk); #1;
    end
    if (rsp_done < target) chk("rsp_wait", 32'(rsp_done), 32'(target));
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int n_rsp = 0, seen, d0, c0;
  logic [1:0] rn;
  logic rr;

  initial begin
    rst = 1'b0;
    drive_idle_req();
    #1 rst = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_dev_cs", 32'(dev_cs), 32'(0));
    chk("rst_dev_din", 32'(dev_din), 32'(0));
    chk("rst_idle", 32'(idle), 32'(1));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two-operand add, drdy four cycles after cs.
    cfg_drdy_en = 1; cfg_drdy_dly = 4; cfg_dout = 8'h08; cfg_busy_len = 0;
    send(8'hF0, 8'h05, 8'h03, 2'd2, 1'b1);
    wait_done(++n_rsp);
    chk("add_cmd_word", 32'(cs_din), 32'h0F0);
    chk("add_data", 32'(last_data), 32'h08);
    chk("add_err", 32'(last_err), 32'(0));

    // Read-only command, drdy the cycle after cs.
    cfg_drdy_dly = 1; cfg_dout = 8'hA5;
    send(8'h11, 8'h00, 8'h00, 2'd0, 1'b1);
    wait_done(++n_rsp);
    chk("ro_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    chk("ro_data", 32'(last_data), 32'hA5);

    // No-response command, busy for 5 cycles, stray drdy ignored.
    cfg_busy_len = 5; cfg_stray = 1; cfg_dout = 8'h77;
    send(8'h22, 8'h44, 8'h00, 2'd1, 1'b0);
    wait_done(++n_rsp);
    chk("nr_after_busy", 32'(rise_cyc > cs_cyc + 5), 32'(1));
    chk("nr_data", 32'(last_data), 32'h00);
    cfg_stray = 0; cfg_busy_len = 0;

    // Response backpressure for 10 cycles with a second request pending.
    rdy_mode = 0; cfg_drdy_dly = 2; cfg_dout = 8'h3C;
    send(8'h33, 8'h00, 8'h00, 2'd0, 1'b1);
    for (int k = 0; k < 50 && !rsp_valid; k++) begin @(posedge clk); #1; end
    req_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_valid", 32'(rsp_valid), 32'(1));
    chk("bp_data", 32'(rsp_data), 32'h3C);
    chk("bp_no_ready", 32'(req_ready), 32'(0));
    req_valid = 1'b0;
    rdy_mode = 1;
    wait_done(++n_rsp);

    // Busy forced high in IDLE blocks acceptance and cs.
    busy_force = 1;
    repeat (2) begin @(posedge clk); #1; end
    c0 = cs_count;
    req_cmd = 8'h55; req_nops = 2'd0; req_rsp = 1'b0; req_valid = 1'b1;
    repeat (6) begin @(negedge clk); chk("gate_ready", 32'(req_ready), 32'(0)); end
    chk("gate_no_cs", 32'(cs_count), 32'(c0));
    @(posedge clk); #1;
    busy_force = 0;
    send(8'h55, 8'h00, 8'h00, 2'd0, 1'b0);
    wait_done(++n_rsp);

    // No drdy: timeout or indefinite wait.
    cfg_drdy_en = 0;
`ifdef CALC_HOST_TIMEOUT_EN
    send(8'h66, 8'h00, 8'h00, 2'd0, 1'b1);
    wait_done(++n_rsp);
    chk("to_err", 32'(last_err), 32'(1));
    chk("to_data", 32'(last_data), 32'h00);
    chk("to_latency", 32'(rise_cyc - cs_cyc), 32'(TO + 1));
    cfg_drdy_en = 1; cfg_drdy_dly = TO; cfg_dout = 8'h9E;
    send(8'h67, 8'h00, 8'h00, 2'd0, 1'b1);
    wait_done(++n_rsp);
    chk("to_tie_err", 32'(last_err), 32'(0));
    chk("to_tie_data", 32'(last_data), 32'h9E);
`else
    send(8'h66, 8'h00, 8'h00, 2'd0, 1'b1);
    seen = 0;
    repeat (100) begin @(posedge clk); #1; seen += int'(rsp_valid); end
    chk("no_to_never_valid", 32'(seen), 32'(0));
    rst_pulse();
`endif

    // Reset during OP1, then a normal request.
    cfg_drdy_en = 0;
    send(8'h77, 8'hC1, 8'hC2, 2'd2, 1'b1);
    @(posedge clk); #3;
    chk("op1_word", 32'(dev_din), 32'hC1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(dev_cs), 32'(0));
    chk("mid_rst_din", 32'(dev_din), 32'(0));
    chk("mid_rst_idle", 32'(idle), 32'(1));
    chk("mid_rst_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    cfg_drdy_en = 1; cfg_drdy_dly = 1; cfg_dout = 8'h5A;
    send(8'h78, 8'h00, 8'h00, 2'd0, 1'b1);
    wait_done(++n_rsp);
    chk("post_rst_data", 32'(last_data), 32'h5A);

    // Randomized transactions with random response backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      rn = 2'($urandom_range(0, 3));
      rr = 1'($urandom_range(0, 1));
      cfg_drdy_en = 1;
      cfg_drdy_dly = 1 + ((rn == 2'd3) ? 2 : int'(rn)) + int'($urandom_range(0, 4));
      cfg_dout = DW'($urandom);
      cfg_busy_len = int'($urandom_range(0, 6));
      cfg_stray = !rr && ($urandom_range(0, 1) == 1);
      send(DW'($urandom), DW'($urandom), DW'($urandom), rn, rr);
      wait_done(++n_rsp);
    end
    cfg_stray = 0;
    rdy_mode = 1;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
